// File: rtl/inter_msg_tx_pkg.sv
// Shared definitions for the interboard message link.
// - frame_t : 24-bit message frame; field order fixes the bit positions
//             (msg_type [23:20] down to parity [0]).
// - beat_of : selects one of the four 6-bit beats, beat0 = frame[23:18].
package inter_msg_tx_pkg;

  localparam int FRAME_W   = 24;
  localparam int BEAT_W    = 6;
  localparam int NUM_BEATS = FRAME_W / BEAT_W;
  localparam int TIMER_W   = 20;

  typedef struct packed {
    logic [3:0] msg_type;  // [23:20]
    logic [5:0] card;      // [19:14]
    logic [2:0] sel_len;   // [13:11]
    logic [4:0] block_x;   // [10:6]
    logic [2:0] block_y;   // [5:3]
    logic       move_dir;  // [2]
    logic       player;    // [1]
    logic       parity;    // [0] odd parity over the whole frame
  } frame_t;

  function automatic logic [BEAT_W-1:0] beat_of(input frame_t f, input logic [1:0] idx);
    logic [FRAME_W-1:0] flat;
    flat = f;
    case (idx)
      2'd0:    beat_of = flat[23:18];
      2'd1:    beat_of = flat[17:12];
      2'd2:    beat_of = flat[11:6];
      default: beat_of = flat[5:0];
    endcase
  endfunction

endpackage

// File: rtl/inter_msg_tx_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset (reset 0).
// - clk_i, rst_i : destination clock and reset
// - d_i          : asynchronous input
// - q_o          : synchronized output, two clk_i edges behind d_i
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/inter_msg_tx.sv
// Interboard message transmitter. Latches one control bundle, packs it into a
// 24-bit frame (player ID + odd parity) and ships it to the peer board as four
// 6-bit beats over a 4-phase request/ack handshake.
// - clk, rst          : clock, asynchronous active-high reset
// - interboard_rst    : synchronous abort back to idle
// - ctrl_*            : bundle, valid while ctrl_en is high
// - inter_ready       : idle, a new bundle will be accepted
// - tx_done / tx_err  : one-cycle pulses, frame acknowledged / ack timeout
// - request_out, ack_in, inter_data_out : 4-phase link to the peer
module inter_msg_tx #(
  parameter bit          PLAYER  = 1'b0,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       ctrl_en,
  input  logic       ctrl_move_dir,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [3:0] ctrl_msg_type,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  output logic       inter_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       request_out,
  input  logic       ack_in,
  output logic [5:0] inter_data_out
);

  import inter_msg_tx_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ_HI = 2'd1,
    S_REQ_LO = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t              state_q;
  logic [1:0]          beat_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                req_q;
  logic [BEAT_W-1:0]   data_q;
  logic                done_q;
  logic                err_q;
  frame_t              frame_q;
  frame_t              frame_d;
  logic [FRAME_W-2:0]  body_d;
  logic                ack_s;
  logic                accept;
  logic                timer_hit;

  sync2 u_ack_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ack_in),
    .q_o   (ack_s)
  );

  // Parity bit makes the total number of ones in the frame odd.
  assign body_d    = {ctrl_msg_type, ctrl_card, ctrl_sel_len, ctrl_block_x,
                      ctrl_block_y, ctrl_move_dir, PLAYER};
  assign frame_d   = {body_d, ~(^body_d)};
  assign accept    = (state_q == S_IDLE) && ctrl_en && !interboard_rst;
  assign timer_hit = (timer_q == TIMER_LAST);

  // Frame holding register: only meaningful while a frame is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_q <= frame_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      timer_q <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (interboard_rst) begin
        state_q <= S_IDLE;
        beat_q  <= 2'd0;
        timer_q <= '0;
        req_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ctrl_en) begin
              state_q <= S_REQ_HI;
              beat_q  <= 2'd0;
              timer_q <= '0;
              req_q   <= 1'b1;
              data_q  <= beat_of(frame_d, 2'd0);
            end
          end
          S_REQ_HI: begin
            if (ack_s) begin
              state_q <= S_REQ_LO;
              req_q   <= 1'b0;
              timer_q <= '0;
            end else if (timer_hit) begin
              state_q <= S_IDLE;
              err_q   <= 1'b1;
              req_q   <= 1'b0;
              data_q  <= '0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
          S_REQ_LO: begin
            // Every beat needs the peer to drop ack before the next request.
            if (!ack_s) begin
              timer_q <= '0;
              if (beat_q == 2'd3) begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
                data_q  <= '0;
                beat_q  <= 2'd0;
              end else begin
                state_q <= S_REQ_HI;
                beat_q  <= beat_q + 2'd1;
                req_q   <= 1'b1;
                data_q  <= beat_of(frame_q, beat_q + 2'd1);
              end
            end else if (timer_hit) begin
              state_q <= S_IDLE;
              err_q   <= 1'b1;
              data_q  <= '0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TIMER_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign inter_ready    = (state_q == S_IDLE);
  assign tx_done        = done_q;
  assign tx_err         = err_q;
  assign request_out    = req_q;
  assign inter_data_out = data_q;

endmodule

// File: tb/tb_inter_msg_tx.sv
module tb_inter_msg_tx;

  localparam int TMO = 16;
  localparam logic [1:0] K_DONE  = 2'd0;
  localparam logic [1:0] K_ERR   = 2'd1;
  localparam logic [1:0] K_ABORT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [23:0] beats;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, irst, en, en_b, dir;
  logic [3:0] mt;
  logic [5:0] card;
  logic [2:0] sl, by;
  logic [4:0] bx;
  logic       ready, done, err, req, ack;
  logic [5:0] data;
  logic       ready_b, done_b, err_b, req_b, ack_b;
  logic [5:0] data_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ndone = 0;
  int ndone_b = 0;
  int nerr_b = 0;
  int exp_done = 0;
  exp_t sbq[$];
  logic [5:0] qb[$];

  inter_msg_tx #(.PLAYER(1'b0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .interboard_rst(irst), .ctrl_en(en),
    .ctrl_move_dir(dir), .ctrl_block_x(bx), .ctrl_block_y(by),
    .ctrl_msg_type(mt), .ctrl_card(card), .ctrl_sel_len(sl),
    .inter_ready(ready), .tx_done(done), .tx_err(err),
    .request_out(req), .ack_in(ack), .inter_data_out(data)
  );

  inter_msg_tx #(.PLAYER(1'b1), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .interboard_rst(irst), .ctrl_en(en_b),
    .ctrl_move_dir(dir), .ctrl_block_x(bx), .ctrl_block_y(by),
    .ctrl_msg_type(mt), .ctrl_card(card), .ctrl_sel_len(sl),
    .inter_ready(ready_b), .tx_done(done_b), .tx_err(err_b),
    .request_out(req_b), .ack_in(ack_b), .inter_data_out(data_b)
  );

  // Peer for board A: echoes request after dly_a cycles, or is silent/stuck.
  int dly_a = 1;
  int mode_a = 0;
  logic [3:0] hist_a;
  always @(posedge clk or posedge rst) begin
    if (rst) hist_a <= '0;
    else     hist_a <= {hist_a[2:0], req};
  end
  always_comb begin
    ack = req;
    if (mode_a == 1)      ack = 1'b0;
    else if (mode_a == 2) ack = 1'b1;
    else if (dly_a > 0)   ack = hist_a[dly_a-1];
  end

  // Peer for board B: echoes request one cycle later.
  logic hist_b;
  always @(posedge clk or posedge rst) begin
    if (rst) hist_b <= 1'b0;
    else     hist_b <= req_b;
  end
  assign ack_b = hist_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: collects beats on each request rise; at every return to idle,
  // pops the expected outcome and compares.
  initial begin : monitor
    logic prev_ready, prev_req, prev_req_b;
    logic [23:0] got;
    logic [1:0] kind;
    exp_t e;
    int nb;
    prev_ready = 1'b1; prev_req = 1'b0; prev_req_b = 1'b0; got = '0; nb = 0;
    forever begin
      @(negedge clk);
      if (done) ndone++;
      if (done_b) ndone_b++;
      if (err_b) nerr_b++;
      if (req_b && !prev_req_b) qb.push_back(data_b);
      if (done || err) chk("pulse_at_idle_entry", {31'd0, ready && !prev_ready}, 32'd1);
      if (req && !prev_req) begin
        if (nb < 4) got[23 - 6*nb -: 6] = data;
        nb++;
      end
      if (ready && !prev_ready) begin
        kind = done ? K_DONE : (err ? K_ERR : K_ABORT);
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected_end: frame ended (kind %0d) with nothing expected", kind);
        end else begin
          e = sbq.pop_front();
          chk("end_kind", {30'd0, kind}, {30'd0, e.kind});
          if (e.kind == K_DONE) begin
            chk("beat_count", nb, 4);
            chk("beats", {8'd0, got}, {8'd0, e.beats});
          end
        end
        nb = 0;
        got = '0;
      end
      prev_ready = ready;
      prev_req = req;
      prev_req_b = req_b;
    end
  end

  // Reference frame built straight from the field layout.
  function automatic logic [23:0] model(input logic [3:0] m, input logic [5:0] c,
                                        input logic [2:0] s, input logic [4:0] x,
                                        input logic [2:0] y, input logic d, input bit player);
    int unsigned v;
    v = (32'(m) << 20) | (32'(c) << 14) | (32'(s) << 11) | (32'(x) << 6)
      | (32'(y) << 3) | (32'(d) << 2) | (32'(player) << 1);
    if (($countones(v) % 2) == 0) v = v | 32'd1;
    return v[23:0];
  endfunction

  task automatic expect_end(input logic [1:0] k, input logic [23:0] b);
    exp_t e;
    e.kind = k;
    e.beats = b;
    sbq.push_back(e);
    if (k == K_DONE) exp_done++;
  endtask

  task automatic drive(input logic [3:0] m, input logic [5:0] c, input logic [2:0] s,
                       input logic [4:0] x, input logic [2:0] y, input logic d, input bit to_b);
    @(negedge clk);
    mt = m; card = c; sl = s; bx = x; by = y; dir = d; en = 1'b1; en_b = to_b;
    @(negedge clk);
    en = 1'b0; en_b = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, k < 400}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, c0, k, falls, rises;
    logic pr;
    logic [3:0] rm; logic [5:0] rc; logic [2:0] rs, ry; logic [4:0] rx; logic rd;
    logic [23:0] bval;

    rst = 1'b1; irst = 1'b0; en = 1'b0; en_b = 1'b0;
    mt = '0; card = '0; sl = '0; bx = '0; by = '0; dir = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_data", {26'd0, data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    // Basic frame, ack one cycle behind request.
    dly_a = 1;
    expect_end(K_DONE, {6'h0D, 6'h05, 6'h09, 6'h24});
    d0 = ndone;
    drive(4'd3, 6'd17, 3'd2, 5'd9, 3'd4, 1'b1, 1'b0);
    chk("first_req", {31'd0, req}, 32'd1);
    chk("first_beat", {26'd0, data}, 32'h0D);
    chk("busy_not_ready", {31'd0, ready}, 32'd0);
    wait_idle("basic_idle");
    chk("basic_done_cnt", ndone - d0, 1);

    // Parity: all-zero bundle on both boards (PLAYER 0 and 1).
    expect_end(K_DONE, 24'h000001);
    qb.delete();
    d0 = ndone_b;
    drive(4'd0, 6'd0, 3'd0, 5'd0, 3'd0, 1'b0, 1'b1);
    wait_idle("parity_idle");
    k = 0;
    while (!ready_b && k < 400) begin @(negedge clk); k++; end
    chk("parity_b_idle", {31'd0, k < 400}, 32'd1);
    repeat (2) @(negedge clk);
    chk("parity_b_nbeats", qb.size(), 4);
    bval = '1;
    if (qb.size() == 4) bval = {qb[0], qb[1], qb[2], qb[3]};
    chk("parity_b_frame", {8'd0, bval}, 32'h000002);
    chk("parity_b_done", ndone_b - d0, 1);

    // Minimum frame length with zero-delay ack echo.
    dly_a = 0;
    expect_end(K_DONE, model(4'd7, 6'd42, 3'd5, 5'd30, 3'd1, 1'b0, 1'b0));
    drive(4'd7, 6'd42, 3'd5, 5'd30, 3'd1, 1'b0, 1'b0);
    c0 = cyc;
    k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    chk("min_frame_cycles", cyc - c0, 24);
    repeat (4) @(negedge clk);

    // Busy ignore: second request two cycles later is dropped.
    dly_a = 1;
    expect_end(K_DONE, model(4'd5, 6'd33, 3'd1, 5'd20, 3'd6, 1'b0, 1'b0));
    d0 = ndone;
    drive(4'd5, 6'd33, 3'd1, 5'd20, 3'd6, 1'b0, 1'b0);
    @(negedge clk);
    mt = 4'd9; card = 6'd1; sl = 3'd7; bx = 5'd3; by = 3'd2; dir = 1'b1; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_idle("busy_idle");
    repeat (6) @(negedge clk);
    chk("busy_done_cnt", ndone - d0, 1);

    // Timeout in REQ_HI: peer never acks.
    mode_a = 1;
    expect_end(K_ERR, 24'h0);
    drive(4'd2, 6'd11, 3'd3, 5'd4, 3'd5, 1'b1, 1'b0);
    c0 = cyc;
    k = 0;
    while (!err && k < 100) begin @(negedge clk); k++; end
    chk("timeout_cycles", cyc - c0, TMO);
    chk("timeout_req", {31'd0, req}, 32'd0);
    chk("timeout_data", {26'd0, data}, 32'd0);
    chk("timeout_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    chk("timeout_pulse_width", {31'd0, err}, 32'd0);
    mode_a = 0;
    repeat (4) @(negedge clk);

    // Timeout in REQ_LO: peer ack stuck high.
    mode_a = 2;
    expect_end(K_ERR, 24'h0);
    drive(4'd1, 6'd2, 3'd3, 5'd4, 3'd5, 1'b0, 1'b0);
    wait_idle("stuck_idle");
    mode_a = 0;
    repeat (6) @(negedge clk);

    // Abort with interboard_rst during beat2 REQ_LO, then a clean frame.
    dly_a = 2;
    expect_end(K_ABORT, 24'h0);
    d0 = ndone;
    drive(4'd3, 6'd17, 3'd2, 5'd9, 3'd4, 1'b1, 1'b0);
    falls = 0; k = 0; pr = req;
    while (falls < 3 && k < 300) begin
      @(negedge clk);
      k++;
      if (pr && !req) falls++;
      pr = req;
    end
    chk("abort_reach", {31'd0, k < 300}, 32'd1);
    chk("abort_beat2_held", {26'd0, data}, 32'h09);
    irst = 1'b1;
    @(negedge clk);
    irst = 1'b0;
    chk("abort_req", {31'd0, req}, 32'd0);
    chk("abort_data", {26'd0, data}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", ndone - d0, 0);
    dly_a = 1;
    expect_end(K_DONE, {6'h0D, 6'h05, 6'h09, 6'h24});
    drive(4'd3, 6'd17, 3'd2, 5'd9, 3'd4, 1'b1, 1'b0);
    wait_idle("after_abort_idle");

    // Randomized frames and peer delays.
    for (int i = 0; i < 20; i++) begin
      dly_a = $urandom_range(0, 3);
      rm = 4'($urandom); rc = 6'($urandom); rs = 3'($urandom);
      rx = 5'($urandom); ry = 3'($urandom); rd = 1'($urandom);
      expect_end(K_DONE, model(rm, rc, rs, rx, ry, rd, 1'b0));
      drive(rm, rc, rs, rx, ry, rd, 1'b0);
      wait_idle("rand_idle");
    end

    // Asynchronous reset during beat1.
    dly_a = 1;
    expect_end(K_ABORT, 24'h0);
    drive(4'd15, 6'd63, 3'd7, 5'd31, 3'd7, 1'b1, 1'b0);
    rises = 1; k = 0; pr = req;
    while (rises < 2 && k < 300) begin
      @(negedge clk);
      k++;
      if (req && !pr) rises++;
      pr = req;
    end
    chk("arst_reach", {31'd0, k < 300}, 32'd1);
    @(posedge clk);
    #1;
    chk("arst_before_req", {31'd0, req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, req}, 32'd0);
    chk("arst_data", {26'd0, data}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    expect_end(K_DONE, model(4'd6, 6'd21, 3'd4, 5'd17, 3'd3, 1'b0, 1'b0));
    drive(4'd6, 6'd21, 3'd4, 5'd17, 3'd3, 1'b0, 1'b0);
    wait_idle("final_idle");

    chk("sb_drained", sbq.size(), 0);
    chk("total_done", ndone, exp_done);
    chk("b_no_err", nerr_b, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inter_msg_tx.md
# inter_msg_tx

Interboard message transmitter for the two-board card game. Sits directly downstream of the game-control handlers, such as the shift handler:
- accepts one control bundle (msg type, card, selection length, block coordinates, move direction) when enabled;
- packs it into a 24-bit frame with player ID and parity;
- sends the frame to the peer board as four 6-bit beats over a 4-phase req/ack link.

`inter_ready` tells upstream handlers when a new bundle may be issued.

## Interface
Parameters:
- PLAYER, 0, this board's player ID, placed in frame bit 1
- TIMEOUT, 1_000_000, cycles to wait for any single ack edge before aborting

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- interboard_rst  in  1  synchronous abort/clear, sampled on clk
- ctrl_en  in  1  one-cycle request; bundle below is valid this cycle
- ctrl_move_dir  in  1  move direction
- ctrl_block_x  in  5  block column
- ctrl_block_y  in  3  block row
- ctrl_msg_type  in  4  message type code
- ctrl_card  in  6  card code
- ctrl_sel_len  in  3  selection length
- inter_ready  out  1  high when idle; a new ctrl_en is accepted
- tx_done  out  1  one-cycle pulse, frame fully acknowledged
- tx_err  out  1  one-cycle pulse, timeout abort
- request_out  out  1  4-phase request to peer
- ack_in  in  1  4-phase ack from peer, asynchronous to clk
- inter_data_out  out  6  beat data to peer

## Operation
Frame layout, [23:0]:
- msg_type [23:20]
- card [19:14]
- sel_len [13:11]
- block_x [10:6]
- block_y [5:3]
- move_dir [2]
- PLAYER [1]
- odd parity [0], chosen so that bits [23:0] contain an odd number of ones.

Beat order: beat0 = [23:18], beat1 = [17:12], beat2 = [11:6], beat3 = [5:0].

Input handling:
- ack_in passes through a 2-flop synchronizer (reset 0). Only ack_s, the synchronized value, is used.
- The frame is latched on acceptance. Inputs may change afterwards without effect.

States:
- IDLE: inter_ready=1. On ctrl_en, latch the frame, clear beat counter and timeout counter, go to REQ_HI.
- REQ_HI: request_out=1, inter_data_out = current beat. When ack_s=1, go to REQ_LO and clear the timer.
- REQ_LO: request_out=0, data held. When ack_s=0:
  - if beat==3, go to IDLE and pulse tx_done;
  - otherwise increment beat, clear the timer, go to REQ_HI.
- Timeout: in REQ_HI or REQ_LO, when the timer reaches TIMEOUT-1 without the awaited edge, pulse tx_err and go to IDLE with outputs cleared.

Boundary conditions:
- ctrl_en outside IDLE is ignored. No queuing; upstream must gate on inter_ready.
- interboard_rst in any state: next cycle IDLE, outputs at reset values, counters cleared, no tx_done/tx_err. It takes priority over ctrl_en in the same cycle.
- rst mid-frame: immediate return to reset values. The peer recovers via interboard_rst.
- ack_s already high on entry to REQ_HI: the handshake still waits for the REQ_LO low phase. There are no shortcuts across beats.

Reset values:
- request_out=0, inter_data_out=0, tx_done=0, tx_err=0
- state IDLE, so inter_ready=1

## Timing
- inter_ready is combinational from state: high in IDLE, low otherwise.
- ctrl_en at cycle N: request_out=1 with beat0 from cycle N+1.
- ack_in rising at cycle M: ack_s high at M+2; request_out falls at M+3.
- The same 2-cycle synchronizer latency plus 1 cycle applies to each ack falling edge.
- The next beat's request_out and data appear together one cycle after the REQ_LO exit.
- tx_done is coincident with the first IDLE cycle.
- Minimum frame length, with ack echoing request in 0 cycles: 4 beats × 6 cycles = 24 cycles.
- Timer: 20 bits. It counts cycles since entering the current REQ state and saturates at the compare.

## Structure
- The frame bit positions, FRAME_W=24 and BEAT_W=6 belong in the shared message macro header, next to the msg_type codes.
- State encodings are local to this block.
- One sub-module: sync2, a generic 2-flop synchronizer with async reset. It is reused by the receiver.
- Parity is an XOR-reduce computed inline.

## Test plan
- Basic frame: PLAYER=0, msg_type=3, card=17, sel_len=2, block_x=9, block_y=4, dir=1, peer ack echoing request with 1-cycle delay -> beats 0x0D, 0x05, 0x09, 0x24 in order; one tx_done; inter_ready back to 1.
- Parity: all-zero bundle with PLAYER=0 -> bit0=1, beat3=0x01. Same bundle with PLAYER=1 -> bit0=0, beat3=0x02.
- Busy ignore: second ctrl_en two cycles after the first, with different fields -> only the first frame is sent, and exactly one tx_done.
- Timeout: TIMEOUT=16, ack held 0 -> tx_err pulse 16 cycles after request_out rises; request_out=0; IDLE.
- Abort: interboard_rst asserted while in beat2 REQ_LO -> next cycle request_out=0, data=0, inter_ready=1, no tx_done. A following frame transmits cleanly.
- Async reset: rst asserted mid-beat1 between clock edges -> outputs zero immediately, without waiting for a clock edge.
